// File: rtl/hsv2rgb_pipe.sv
// Four-stage pipelined HSV-to-RGB converter. Hue is split into a sector and
// a fraction, then the three colour levels are formed with div255 scaling only.
module hsv2rgb_pipe #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_en,
    input  logic        valid_in,
    input  logic [23:0] hsv_in,
    input  logic [2:0]  sync_in,
    output logic        valid_out,
    output logic [23:0] rgb_out,
    output logic [2:0]  sync_out
);

    // Exact floor(x/255) for 0 <= x <= 65025 using a 17-bit intermediate.
    function automatic logic [7:0] div255(input logic [15:0] x);
        logic [16:0] sum;
        sum = {1'b0, x} + {9'b0, x[15:8]} + 17'd1;
        return sum[15:8];
    endfunction

    // Stage 1: sector decode and first products
    logic [7:0]  h_in, s_in, v_in;
    logic [10:0] hx;
    logic [2:0]  sec1_d, sec1_q;
    logic [7:0]  f1_d, f1_q, v1_q;
    logic [15:0] sf_raw_d, sfn_raw_d, p_raw_d;
    logic [15:0] sf_raw_q, sfn_raw_q, p_raw_q;

    // Stage 2: scaled saturation terms and p
    logic [7:0]  sf_d, sfn_d, p2_d;
    logic [7:0]  sf_q, sfn_q, p2_q, v2_q;
    logic [2:0]  sec2_q;

    // Stage 3: products for q and t
    logic [15:0] q_raw_d, t_raw_d, q_raw_q, t_raw_q;
    logic [7:0]  p3_q, v3_q;
    logic [2:0]  sec3_q;

    // Stage 4: final scaling and sector mux
    logic [7:0]  q4, t4;
    logic [23:0] rgb_d, rgb_q;

    logic [LATENCY-1:0] vld_q;
    logic [2:0]         sb_q [LATENCY];

    always_comb begin
        h_in      = hsv_in[23:16];
        s_in      = hsv_in[15:8];
        v_in      = hsv_in[7:0];
        hx        = {3'b0, h_in} * 11'd6;
        sec1_d    = hx[10:8];
        f1_d      = hx[7:0];
        sf_raw_d  = {8'b0, s_in} * {8'b0, f1_d};
        sfn_raw_d = {8'b0, s_in} * {8'b0, 8'd255 - f1_d};
        p_raw_d   = {8'b0, v_in} * {8'b0, 8'd255 - s_in};
    end

    always_comb begin
        sf_d  = div255(sf_raw_q);
        sfn_d = div255(sfn_raw_q);
        p2_d  = div255(p_raw_q);
    end

    always_comb begin
        q_raw_d = {8'b0, v2_q} * {8'b0, 8'd255 - sf_q};
        t_raw_d = {8'b0, v2_q} * {8'b0, 8'd255 - sfn_q};
    end

    always_comb begin
        q4 = div255(q_raw_q);
        t4 = div255(t_raw_q);
        case (sec3_q)
            3'd0:    rgb_d = {v3_q, t4,   p3_q};
            3'd1:    rgb_d = {q4,   v3_q, p3_q};
            3'd2:    rgb_d = {p3_q, v3_q, t4};
            3'd3:    rgb_d = {p3_q, q4,   v3_q};
            3'd4:    rgb_d = {t4,   p3_q, v3_q};
            3'd5:    rgb_d = {v3_q, p3_q, q4};
            default: rgb_d = 24'd0;
        endcase
    end

    // Colour data advances on every enabled cycle; valid only tags it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec1_q    <= '0;
            f1_q      <= '0;
            v1_q      <= '0;
            sf_raw_q  <= '0;
            sfn_raw_q <= '0;
            p_raw_q   <= '0;
            sf_q      <= '0;
            sfn_q     <= '0;
            p2_q      <= '0;
            v2_q      <= '0;
            sec2_q    <= '0;
            q_raw_q   <= '0;
            t_raw_q   <= '0;
            p3_q      <= '0;
            v3_q      <= '0;
            sec3_q    <= '0;
            rgb_q     <= '0;
            vld_q     <= '0;
            for (int i = 0; i < LATENCY; i++) sb_q[i] <= '0;
        end else if (pipe_en) begin
            sec1_q    <= sec1_d;
            f1_q      <= f1_d;
            v1_q      <= v_in;
            sf_raw_q  <= sf_raw_d;
            sfn_raw_q <= sfn_raw_d;
            p_raw_q   <= p_raw_d;
            sf_q      <= sf_d;
            sfn_q     <= sfn_d;
            p2_q      <= p2_d;
            v2_q      <= v1_q;
            sec2_q    <= sec1_q;
            q_raw_q   <= q_raw_d;
            t_raw_q   <= t_raw_d;
            p3_q      <= p2_q;
            v3_q      <= v2_q;
            sec3_q    <= sec2_q;
            rgb_q     <= rgb_d;
            vld_q     <= {vld_q[LATENCY-2:0], valid_in};
            sb_q[0]   <= sync_in;
            for (int i = 1; i < LATENCY; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    assign valid_out = vld_q[LATENCY-1];
    assign rgb_out   = rgb_q;
    assign sync_out  = sb_q[LATENCY-1];

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Directed bench for hsv2rgb_pipe: expected pixels are queued with the enabled
// edge on which they must appear and checked by a monitor after each edge.
module tb_hsv2rgb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_en;
    logic        valid_in;
    logic [23:0] hsv_in;
    logic [2:0]  sync_in;
    logic        valid_out;
    logic [23:0] rgb_out;
    logic [2:0]  sync_out;

    hsv2rgb_pipe #(.LATENCY(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_en   (pipe_en),
        .valid_in  (valid_in),
        .hsv_in    (hsv_in),
        .sync_in   (sync_in),
        .valid_out (valid_out),
        .rgb_out   (rgb_out),
        .sync_out  (sync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  sy;
        int          tgt;
    } exp_t;

    exp_t        sb_q[$];
    int          vecs = 0;
    int          errs = 0;
    int          en_cnt = 0;
    logic        last_v;
    logic [23:0] last_rgb;
    logic [2:0]  last_sy;

    function automatic int d255(input int x);
        return x / 255;
    endfunction

    function automatic logic [23:0] model(input int h, input int s, input int v);
        int hx, sec, f, sf, sfn, p, q, t;
        logic [7:0] r, g, b;
        hx  = h * 6;
        sec = hx / 256;
        f   = hx % 256;
        sf  = d255(s * f);
        sfn = d255(s * (255 - f));
        p   = d255(v * (255 - s));
        q   = d255(v * (255 - sf));
        t   = d255(v * (255 - sfn));
        case (sec)
            0: begin r = 8'(v); g = 8'(t); b = 8'(p); end
            1: begin r = 8'(q); g = 8'(v); b = 8'(p); end
            2: begin r = 8'(p); g = 8'(v); b = 8'(t); end
            3: begin r = 8'(p); g = 8'(q); b = 8'(v); end
            4: begin r = 8'(t); g = 8'(p); b = 8'(v); end
            default: begin r = 8'(v); g = 8'(p); b = 8'(q); end
        endcase
        return {r, g, b};
    endfunction

    // Monitor: checks every enabled edge, and output hold on stalled edges.
    always @(posedge clk) begin
        logic en_s, exp_v;
        exp_t e;
        en_s = pipe_en;
        if (rst_n) begin
            if (en_s) en_cnt++;
            #1;
            if (!en_s) begin
                vecs++;
                assert ({valid_out, rgb_out, sync_out} === {last_v, last_rgb, last_sy}) else begin
                    errs++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {valid_out, rgb_out, sync_out}, {last_v, last_rgb, last_sy});
                end
            end else begin
                exp_v = (sb_q.size() > 0) && (sb_q[0].tgt == en_cnt);
                vecs++;
                assert (valid_out === exp_v) else begin
                    errs++;
                    $error("FAIL valid_out edge=%0d observed=%b expected=%b", en_cnt, valid_out, exp_v);
                end
                if (exp_v) begin
                    e = sb_q.pop_front();
                    vecs++;
                    assert ({rgb_out, sync_out} === {e.rgb, e.sy}) else begin
                        errs++;
                        $error("FAIL pixel edge=%0d observed rgb=%h sync=%b expected rgb=%h sync=%b",
                               en_cnt, rgb_out, sync_out, e.rgb, e.sy);
                    end
                end
                while (sb_q.size() > 0 && sb_q[0].tgt < en_cnt) begin
                    e = sb_q.pop_front();
                    errs++;
                    $error("FAIL lost_pixel observed=none expected rgb=%h", e.rgb);
                end
            end
        end else begin
            #1;
        end
        last_v   = valid_out;
        last_rgb = rgb_out;
        last_sy  = sync_out;
    end

    task automatic drive(input logic v, input logic [23:0] hsv, input logic [2:0] sy,
                         input logic en, input logic [23:0] exp_rgb);
        exp_t e;
        @(negedge clk);
        pipe_en  = en;
        valid_in = v;
        hsv_in   = hsv;
        sync_in  = sy;
        if (en && v && rst_n) begin
            e.rgb = exp_rgb;
            e.sy  = sy;
            e.tgt = en_cnt + 4;
            sb_q.push_back(e);
        end
    endtask

    task automatic px(input int h, input int s, input int v, input logic [2:0] sy);
        drive(1'b1, {8'(h), 8'(s), 8'(v)}, sy, 1'b1, model(h, s, v));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 24'($urandom), 3'($urandom), 1'b1, 24'd0);
    endtask

    task automatic check_zero(input string tag);
        vecs++;
        assert ({valid_out, rgb_out, sync_out} === 28'd0) else begin
            errs++;
            $error("FAIL %s observed v=%b rgb=%h sync=%b expected all zero", tag, valid_out, rgb_out, sync_out);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pipe_en  = 1'b0;
        valid_in = 1'b0;
        hsv_in   = 24'h0;
        sync_in  = 3'b0;
        #12;
        check_zero("reset_state");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Primaries and boundary fractions with hand-derived results
        drive(1'b1, {8'd0,   8'd255, 8'd255}, 3'b001, 1'b1, {8'd255, 8'd0,   8'd0});
        drive(1'b1, {8'd128, 8'd255, 8'd200}, 3'b010, 1'b1, {8'd0,   8'd200, 8'd200});
        drive(1'b1, {8'd85,  8'd255, 8'd255}, 3'b100, 1'b1, {8'd1,   8'd255, 8'd0});
        drive(1'b1, {8'd255, 8'd255, 8'd255}, 3'b011, 1'b1, {8'd255, 8'd0,   8'd5});
        idle(5);

        // Sideband walking pattern with distinct pixels
        for (int i = 0; i < 6; i++)
            px(i * 40 + 7, 180 + i * 10, 90 + i * 25, 3'(1 << (i % 3)));
        idle(5);

        // Stall for 3 cycles in the middle of an 8-pixel burst
        for (int i = 0; i < 4; i++) px(i * 61 + 3, 255 - i * 30, 250 - i * 11, 3'(i));
        for (int i = 0; i < 3; i++) drive(1'b1, 24'($urandom), 3'b111, 1'b0, 24'd0);
        for (int i = 4; i < 8; i++) px(i * 29 + 11, 120 + i * 9, 60 + i * 20, 3'(i));
        idle(6);

        // Greyscale: S=0 yields V on every channel regardless of hue
        for (int h = 0; h < 256; h++)
            drive(1'b1, {8'(h), 8'd0, 8'd128}, 3'($urandom), 1'b1, {8'd128, 8'd128, 8'd128});
        idle(5);

        // Asynchronous reset with pixels in flight
        for (int i = 0; i < 4; i++) px(i * 50 + 20, 200, 180 + i, 3'b101);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_zero("async_reset");
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        #2 rst_n = 1'b1;
        px(200, 150, 222, 3'b110);
        idle(8);

        vecs++;
        assert (sb_q.size() == 0) else begin
            errs++;
            $error("FAIL drain observed=%0d pending expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hsv2rgb_pipe.md
# hsv2rgb_pipe

Pipelined HSV-to-RGB converter and the return path for the HSV enhancement stage: it takes the adjusted 24-bit HSV pixel stream and produces 24-bit RGB for the VGA output. Sync and blank sideband bits travel with each pixel so they stay aligned with the colour data. The block uses integer arithmetic only (no dividers) and has a fixed 4-cycle latency, with a global clock-enable for stalling.

## Interface
- `LATENCY`, 4: pipeline depth in cycles. Fixed; exposed for downstream alignment only.
- `clk`  in  1  pixel clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pipe_en`  in  1  clock enable; low = every pipeline register holds.
- `valid_in`  in  1  `hsv_in` and sideband are valid this cycle.
- `hsv_in`  in  24  {H[23:16], S[15:8], V[7:0]}; H 0..255 maps to 0..360°.
- `sync_in`  in  3  {hsync, vsync, blank}; delayed with the pixel.
- `valid_out`  out  1  `rgb_out` is valid.
- `rgb_out`  out  24  {R[23:16], G[15:8], B[7:0]}.
- `sync_out`  out  3  `sync_in` delayed by exactly `LATENCY` enabled cycles.

## Operation
- `div255(x)` is defined as `(x + (x>>8) + 1) >> 8`, a 17-bit intermediate. It equals floor(x/255) exactly for 0 ≤ x ≤ 65025. This is the only division used.
- Sector decode:
  - `hx = H*6` (11 bits).
  - `sec = hx[10:8]`, range 0..5.
  - `f = hx[7:0]`.
- Stage 1, registered:
  - sec, f, V.
  - `sf_raw = S*f` (16 b), `sfn_raw = S*(255-f)` (16 b), `p_raw = V*(255-S)` (16 b).
- Stage 2, registered:
  - `sf = div255(sf_raw)`, `sfn = div255(sfn_raw)`, `p = div255(p_raw)`.
  - sec and V are passed along.
- Stage 3, registered:
  - `q_raw = V*(255-sf)`, `t_raw = V*(255-sfn)`.
  - p, sec and V are passed along.
- Stage 4, registered output; `q = div255(q_raw)`, `t = div255(t_raw)`. Output mux by sec:
  - 0: (V, t, p)
  - 1: (q, V, p)
  - 2: (p, V, t)
  - 3: (p, q, V)
  - 4: (t, p, V)
  - 5: (V, p, q)
  - sec values 6 and 7 cannot occur; if they do, output (0, 0, 0).
- S = 0 must give R = G = B = V for any H. This follows from the arithmetic above; no special-case path is needed.
- Data moves through the pipeline regardless of `valid_in`. `valid_in` and `sync_in` are carried in parallel shift registers of depth 4.
- No overflow handling is needed: every product is at most 65025 and every `div255` result is at most 255.

## Timing
- Reset (asynchronous, `rst_n` low): `rgb_out` = 0, `valid_out` = 0, `sync_out` = 3'b000. All internal stage registers and valid/sideband registers are cleared immediately, with no clock required.
- Latency: an input accepted on edge N (with `pipe_en` = 1) appears on the outputs after edge N+3. This is 4 enabled edges in total, counting the capture edge.
- Throughput: one pixel per enabled cycle, with no bubbles.
- `pipe_en` = 0: all registers hold, including `valid_out`, `rgb_out` and `sync_out`, so the outputs stay constant. Inputs presented during that cycle are not captured.
- `pipe_en` resuming: the pipeline continues from its held state. No pixel is lost or duplicated.
- Reset released mid-stream: pixels that were in flight are discarded. `valid_out` stays 0 until 4 enabled cycles after the first `valid_in` = 1 following release.
- `valid_out` changes in the same cycle as the corresponding `rgb_out` and `sync_out`.

## Test plan
- Primaries: H=0, S=255, V=255 with `valid_in`=1 → 4 cycles later `rgb_out` = (255, 0, 0) and `valid_out` = 1. H=128, S=255, V=200 (sec 3, f=0) → (0, 200, 200).
- Boundary fraction: H=85, S=255, V=255 (hx=510, sec 1, f=254) → (1, 255, 0). H=255, S=255, V=255 (hx=1530, sec 5, f=250) → (255, 0, 5). Check: `sf = div255(255*250) = 250`, so `q = div255(255*5) = 5`.
- Greyscale: S=0, V=128, sweep H over 0..255 → every output is (128, 128, 128).
- Sideband alignment: drive `sync_in` with a walking pattern 3'b001, 3'b010, 3'b100 on consecutive cycles alongside distinct pixels → `sync_out` matches each pixel 4 cycles later.
- Stall: stream 8 pixels with `pipe_en` = 0 for 3 cycles in the middle → outputs hold during the stall, and the output sequence equals the input sequence with no loss or repeat.
- Async reset: pull `rst_n` low between clock edges while 4 valid pixels are in flight → `rgb_out`, `valid_out` and `sync_out` go to 0 before the next edge. After release, send one pixel → `valid_out` pulses exactly 4 cycles later.
